// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------------------------------------------------------------------
// Control FSM for a multi-cycle MIPS-subset datapath. One memory port, one ALU
// and the operand/result muxes are shared across instruction phases; this
// block sequences those phases from the IR opcode field and drives the
// datapath control inputs. Outputs are Moore-style (a function of state),
// except that mem_ready and zero qualify the few strobes that depend on a
// memory completion or a branch outcome.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; forces state to FETCH
//   opcode      instruction[31:26] from the instruction register
//   zero        ALU zero flag
//   mem_ready   memory completes the current read/write this cycle
//   pc_write    PC load enable
//   iord        memory address select (0 = PC, 1 = ALUOut)
//   mem_read    memory read request
//   mem_write   memory write request
//   ir_write    instruction register load
//   reg_write   register file write enable
//   reg_dst     write-register select (00 rt, 01 rd, 10 r31)
//   mem_to_reg  write-data select (00 ALUOut, 01 MDR, 10 PC)
//   alu_src_a   ALU A select (0 = PC, 1 = regA)
//   alu_src_b   ALU B select (00 regB, 01 4, 10 imm, 11 imm<<2)
//   alu_op      ALU control (00 add, 01 sub, 10 funct-decoded)
//   pc_source   PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   retire      pulse in the last cycle of each instruction
//   illegal_op  pulse in DECODE when the opcode is unsupported
//   state       current state, for debug and verification
// ---------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; every output defaults to 0 so unused
  // encodings fall back to FETCH with everything deasserted.
  always_comb begin
    next_state_s = S_FETCH;
    pc_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    pc_source    = 2'b00;
    retire       = 1'b0;
    illegal_op   = 1'b0;

    case (state_r)
      S_FETCH: begin
        // PC+4 computed by the ALU; IR and PC commit only when memory answers.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target precomputed speculatively into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JUMP;
          OP_JAL:       next_state_s = S_JAL;
          default: begin
            illegal_op   = 1'b1;
            retire       = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_EXEC: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b10;
        next_state_s = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        retire     = 1'b1;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk, reset;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, retire, illegal_op;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .retire(retire),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // all outputs except state, in a fixed order
  logic [18:0] obs;
  assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, retire, illegal_op};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] op; logic mr; logic z;
    logic [3:0] st; logic pcw; logic rw; logic mw; logic ret; logic ill;
    logic [5:0] sel;   // {reg_dst, mem_to_reg, pc_source}
  } vec_t;
  vec_t vecs [25];

  // ---------------- reference model ----------------
  logic [18:0] base_tbl [0:12];   // fixed output pattern of each phase
  int          plan [$];          // phases of the current instruction
  logic        plan_legal;
  logic [5:0]  legal_ops [7];

  function automatic void build_plan(input logic [5:0] op);
    plan = {};
    plan.push_back(0);
    plan.push_back(1);
    plan_legal = 1'b1;
    case (op)
      6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      6'b101011: begin plan.push_back(2); plan.push_back(5); end
      6'b000000: begin plan.push_back(6); plan.push_back(7); end
      6'b000100: plan.push_back(8);
      6'b001000: begin plan.push_back(10); plan.push_back(11); end
      6'b000010: plan.push_back(9);
      6'b000011: plan.push_back(12);
      default:   plan_legal = 1'b0;
    endcase
  endfunction

  initial begin
    logic [14:0] got15, exp15;
    logic [18:0] e;
    logic [5:0]  cur_op;
    int idx, st;
    logic waitst, adv, last;

    //                pcw iord mrd mwr irw rw  rd    mtr   asa asb   aop   pcs   ret ill
    base_tbl[0]  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
    base_tbl[1]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
    base_tbl[2]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    base_tbl[3]  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    base_tbl[4]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    base_tbl[5]  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    base_tbl[6]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
    base_tbl[7]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    base_tbl[8]  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0};
    base_tbl[9]  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0};
    base_tbl[10] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
    base_tbl[11] = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    base_tbl[12] = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0};

    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};

    //          op     mr    z     st    pcw   rw    mw    ret   ill   sel
    vecs[0]  = '{6'h23,1'b0,1'b0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000}; // fetch stall
    vecs[1]  = '{6'h23,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[2]  = '{6'h23,1'b1,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[3]  = '{6'h23,1'b1,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[4]  = '{6'h23,1'b1,1'b0,4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[5]  = '{6'h23,1'b1,1'b0,4'd4, 1'b0,1'b1,1'b0,1'b1,1'b0,6'b000100};
    vecs[6]  = '{6'h2B,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000}; // SW
    vecs[7]  = '{6'h2B,1'b1,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[8]  = '{6'h2B,1'b1,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[9]  = '{6'h2B,1'b0,1'b0,4'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,6'b000000};
    vecs[10] = '{6'h2B,1'b0,1'b0,4'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,6'b000000};
    vecs[11] = '{6'h2B,1'b0,1'b0,4'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,6'b000000};
    vecs[12] = '{6'h2B,1'b1,1'b0,4'd5, 1'b0,1'b0,1'b1,1'b1,1'b0,6'b000000};
    vecs[13] = '{6'h04,1'b1,1'b1,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000}; // BEQ taken
    vecs[14] = '{6'h04,1'b1,1'b1,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[15] = '{6'h04,1'b1,1'b1,4'd8, 1'b1,1'b0,1'b0,1'b1,1'b0,6'b000001};
    vecs[16] = '{6'h04,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000}; // BEQ not taken
    vecs[17] = '{6'h04,1'b1,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[18] = '{6'h04,1'b1,1'b0,4'd8, 1'b0,1'b0,1'b0,1'b1,1'b0,6'b000001};
    vecs[19] = '{6'h03,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000}; // JAL
    vecs[20] = '{6'h03,1'b1,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,6'b000000};
    vecs[21] = '{6'h03,1'b1,1'b0,4'd12,1'b1,1'b1,1'b0,1'b1,1'b0,6'b101010};
    vecs[22] = '{6'h3F,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000}; // illegal
    vecs[23] = '{6'h3F,1'b1,1'b0,4'd1, 1'b0,1'b0,1'b0,1'b1,1'b1,6'b000000};
    vecs[24] = '{6'h3F,1'b1,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,6'b000000};

    // reset state: FETCH values with mem_ready gating (mem_ready=0 here)
    reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_state", {28'd0, state}, 32'd0);
    e = base_tbl[0];
    check("reset_outs", {13'd0, obs}, {13'd0, e});
    mem_ready = 1'b1;
    #1;
    e[18] = 1'b1; e[14] = 1'b1;
    check("reset_outs_ready", {13'd0, obs}, {13'd0, e});

    // ---------------- directed table ----------------
    do_reset();
    for (int i = 0; i < 25; i++) begin
      opcode = vecs[i].op; mem_ready = vecs[i].mr; zero = vecs[i].z;
      #1;
      got15 = {state, pc_write, reg_write, mem_write, retire, illegal_op, reg_dst, mem_to_reg, pc_source};
      exp15 = {vecs[i].st, vecs[i].pcw, vecs[i].rw, vecs[i].mw, vecs[i].ret, vecs[i].ill, vecs[i].sel};
      check($sformatf("vec%0d", i), {17'd0, got15}, {17'd0, exp15});
      @(negedge clk);
    end

    // ---------------- async reset mid-EXEC ----------------
    do_reset();
    opcode = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
    for (int k = 0; k < 10 && state != 4'd6; k++) @(negedge clk);
    check("reach_exec", {28'd0, state}, 32'd6);
    mem_ready = 1'b0;
    #2 reset = 1'b1;   // between clock edges
    #1;
    check("async_rst_state", {28'd0, state}, 32'd0);
    check("async_rst_regw", {31'd0, reg_write}, 32'd0);
    check("async_rst_irw_gated", {30'd0, ir_write, pc_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    check("post_rst_fetch", {26'd0, state, ir_write, pc_write}, {26'd0, 4'd0, 1'b1, 1'b1});
    @(negedge clk);
    #1;
    check("post_rst_decode", {28'd0, state}, 32'd1);

    // ---------------- randomized vs. phase-plan model ----------------
    do_reset();
    idx = 0;
    cur_op = 6'd0;
    for (int n = 0; n < 3000; n++) begin
      if (idx == 0) begin
        int r;
        r = $urandom_range(0, 8);
        if (r < 7) cur_op = legal_ops[r];
        else if (r == 7) cur_op = 6'b111111;
        else cur_op = 6'b010101;
        build_plan(cur_op);
      end
      opcode = cur_op;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = $urandom_range(0, 1) != 0;
      #1;
      st = plan[idx];
      waitst = (st == 0) || (st == 3) || (st == 5);
      adv = !waitst || mem_ready;
      last = (idx == plan.size() - 1);
      e = base_tbl[st];
      if (st == 0) begin e[18] = mem_ready; e[14] = mem_ready; end
      if (st == 8) e[18] = zero;
      e[1] = last && adv;
      e[0] = (st == 1) && !plan_legal;
      check($sformatf("rand%0d_op%h", n, cur_op), {9'd0, state, obs}, {9'd0, st[3:0], e});
      if (adv) begin
        idx++;
        if (idx == plan.size()) idx = 0;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
